control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - FETCH/WAIT/EXEC/HALT sequencer and decoder for a small accumulator CPU.
// Optional retired-instruction counter enabled by defining CU_INSTR_COUNT_EN.
module control_unit #(
   parameter int NBITS_D    = 16,
   parameter int NBITS_OP   = 5,
   parameter int NBITS_ADDR = 11
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_Enable,
   input  logic [NBITS_D-1:0]    i_Instruction,
   output logic [NBITS_ADDR-1:0] o_PC,
   output logic                  o_Fetch,
   output logic [NBITS_ADDR-1:0] o_Operand,
   output logic [1:0]            o_SelA,
   output logic                  o_SelB,
   output logic                  o_WrAcc,
   output logic                  o_Op,
   output logic                  o_WrRAM,
   output logic                  o_RdRAM,
   output logic                  o_Halt,
   output logic [15:0]           o_InstrCount
);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

   localparam logic [NBITS_OP-1:0] OP_HLT  = NBITS_OP'(0);
   localparam logic [NBITS_OP-1:0] OP_STO  = NBITS_OP'(1);
   localparam logic [NBITS_OP-1:0] OP_LD   = NBITS_OP'(2);
   localparam logic [NBITS_OP-1:0] OP_LDI  = NBITS_OP'(3);
   localparam logic [NBITS_OP-1:0] OP_ADD  = NBITS_OP'(4);
   localparam logic [NBITS_OP-1:0] OP_ADDI = NBITS_OP'(5);
   localparam logic [NBITS_OP-1:0] OP_SUB  = NBITS_OP'(6);
   localparam logic [NBITS_OP-1:0] OP_SUBI = NBITS_OP'(7);

   state_t                  state_q, state_d;
   logic [NBITS_ADDR-1:0]   pc_q, pc_d;
   logic [NBITS_D-1:0]      ir_q, ir_d;
   logic [NBITS_OP-1:0]     opcode;

   assign opcode = ir_q[NBITS_D-1 -: NBITS_OP];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      unique case (state_q)
         S_FETCH: if (i_Enable) state_d = S_WAIT;
         S_WAIT: begin
            ir_d    = i_Instruction;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (opcode == OP_HLT) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
               pc_d    = pc_q + NBITS_ADDR'(1);
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

`ifdef CU_INSTR_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Every EXEC exit retires an instruction, HLT and undefined opcodes included.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_EXEC) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign o_InstrCount = cnt_q;
`else
   assign o_InstrCount = 16'd0;
`endif

   // Decode is purely from state and IR so an async reset clears the enables at once.
   always_comb begin
      o_SelA  = 2'b11;
      o_SelB  = 1'b0;
      o_WrAcc = 1'b0;
      o_Op    = 1'b0;
      o_WrRAM = 1'b0;
      o_RdRAM = 1'b0;
      if (state_q == S_EXEC) begin
         case (opcode)
            OP_STO: o_WrRAM = 1'b1;
            OP_LD: begin
               o_RdRAM = 1'b1;
               o_SelA  = 2'b00;
               o_WrAcc = 1'b1;
            end
            OP_LDI: begin
               o_SelA  = 2'b01;
               o_WrAcc = 1'b1;
            end
            OP_ADD, OP_SUB: begin
               o_RdRAM = 1'b1;
               o_SelA  = 2'b10;
               o_Op    = (opcode == OP_SUB);
               o_WrAcc = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
               o_SelB  = 1'b1;
               o_SelA  = 2'b10;
               o_Op    = (opcode == OP_SUBI);
               o_WrAcc = 1'b1;
            end
            default: o_SelA = 2'b11;
         endcase
      end
   end

   assign o_Fetch   = (state_q == S_FETCH) && i_Enable;
   assign o_Halt    = (state_q == S_HALT);
   assign o_PC      = pc_q;
   assign o_Operand = ir_q[NBITS_ADDR-1:0];

endmodule
